// File: rtl/mul_pkg.sv
// Shared types and default sizing for the multiplier arbiter slice.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mul_state_t;

    localparam int MUL_W_DEF       = 4096;
    localparam int MUL_TIMEOUT_DEF = 8192;

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side handshakes plus the multiplier core link, bundled for the arbiter.
interface mul_arbiter_if import mul_pkg::*; #(
    parameter int W    = MUL_W_DEF,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done;
    logic [W-1:0]      mul_o;
    logic              busy;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_o,
        output req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy
    );

    // Requesters and the core, seen from outside the arbiter.
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_o,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping at N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int             s;
    logic [IDW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = 0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            k = IDW'(s);
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier core among NREQ requesters,
// with a watchdog that turns a missing mul_done into an error response.
module mul_arbiter import mul_pkg::*; #(
    parameter int W       = MUL_W_DEF,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = MUL_TIMEOUT_DEF,
    parameter int IDW     = $clog2(NREQ)
) (
    input logic          clk,
    input logic          rst,
    mul_arbiter_if.slave bus
);

    localparam int WDW = $clog2(TIMEOUT) + 1;

    mul_state_t     state, state_n;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic           pick_any;
    logic [WDW-1:0] wdog;
    logic           timeout_hit;
    logic           rsp_accept;

    rr_pick #(.N(NREQ), .IDW(IDW)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign timeout_hit = (wdog == WDW'(TIMEOUT - 1));
    assign rsp_accept  = bus.rsp_ready[cur_id];

    // req_ready is gated by rst so nothing is handed over while reset is held.
    always_comb begin
        state_n       = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.mul_start = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_any && rst) begin
                    bus.req_ready = pick_gnt;
                    state_n       = ISSUE;
                end
            end
            ISSUE: begin
                bus.mul_start = 1'b1;
                state_n       = WAIT;
            end
            WAIT: begin
                if (bus.mul_done || timeout_hit) state_n = RESP;
            end
            RESP: begin
                bus.rsp_valid[cur_id] = 1'b1;
                if (rsp_accept) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            wdog         <= '0;
            bus.mul_a    <= '0;
            bus.mul_b    <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        cur_id    <= pick_idx;
                        bus.mul_a <= bus.req_a[int'(pick_idx)*W +: W];
                        bus.mul_b <= bus.req_b[int'(pick_idx)*W +: W];
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A done in the same cycle as the timeout still delivers the real result.
                    if (bus.mul_done) begin
                        bus.rsp_data <= bus.mul_o;
                        bus.rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        bus.rsp_data <= '0;
                        bus.rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_accept)
                        rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one wide shift-add multiplier core among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes.
- Issues one job at a time to the core and watches for its done pulse with a timeout watchdog.
- Returns the low W bits of the product to the requester that issued the job.
- Sits between the crypto/modexp front-ends and the single multiplier instance.

Parameters:
W, 4096, operand and result width in bits
NREQ, 4, number of requesters (2..8)
TIMEOUT, 8192, maximum core cycles from mul_start to mul_done before abort
IDW, 2, requester index width, equal to clog2(NREQ)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-low reset
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted this cycle, one-hot or zero
req_a  in  NREQ*W  flattened operand A; requester k uses bits [k*W +: W]
req_b  in  NREQ*W  flattened operand B, same packing as req_a
rsp_valid  out  NREQ  response valid, one-hot or zero
rsp_ready  in  NREQ  response accepted by requester
rsp_data  out  W  shared result bus, valid for the requester whose rsp_valid bit is set
rsp_err  out  1  qualifies rsp_data: 1 = timeout abort, rsp_data is 0
mul_start  out  1  one-cycle start pulse to the core
mul_a  out  W  registered operand A to the core
mul_b  out  W  registered operand B to the core
mul_done  in  1  one-cycle completion pulse from the core
mul_o  in  W  core result, sampled only when mul_done = 1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst = 0 at posedge): state IDLE, rr_ptr = 0, all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy), watchdog counter 0. Reset mid-job abandons the job silently; a later mul_done is ignored because it arrives in IDLE.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - Assert req_ready[g] combinationally in the same cycle; the transfer occurs in that cycle.
  - Latch req_a/req_b slice g into mul_a/mul_b, store g in cur_id, go to ISSUE.
- ISSUE: mul_start = 1 for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT:
  - Increment the watchdog each cycle.
  - On mul_done: rsp_data <= mul_o, rsp_err <= 0, go to RESP.
  - When the watchdog reaches TIMEOUT-1 without mul_done: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - If mul_done arrives in the same cycle as the timeout, mul_done wins.
- RESP:
  - rsp_valid[cur_id] = 1; rsp_data and rsp_err stay stable until rsp_ready[cur_id] = 1.
  - On acceptance: rr_ptr <= (cur_id + 1) mod NREQ, go to IDLE.
  - rsp_ready bits for other requesters are ignored.
- mul_done outside WAIT is ignored.
- mul_a/mul_b hold their values until the next grant.
- No new request is accepted while busy; minimum turnaround per job is core latency + 3 cycles.
- Fairness: any requester holding valid is granted within NREQ jobs.
- req_valid may drop without being granted; no state is kept for it.

Decomposition:
- Package mul_pkg holds:
  - state enum type mul_state_t {IDLE, ISSUE, WAIT, RESP};
  - default constants for W and TIMEOUT.
- One sub-module: rr_pick.
  - Combinational rotating priority encoder.
  - Inputs: req vector and pointer. Outputs: one-hot grant and index.
  - Reused by later arbiters.

Test Plan (W=16, NREQ=4, TIMEOUT=64, behavioural core model with fixed 16-cycle latency):
1. Reset held 3 cycles with req_valid = 4'b1111 -> all outputs 0, no req_ready during reset; first grant after release goes to requester 0.
2. Requester 2 sends a=16'h0013, b=16'h0007 -> mul_start one cycle after req_ready[2]; rsp_valid = 4'b0100, rsp_data = 16'h0085, rsp_err = 0, held until rsp_ready[2].
3. All four valid continuously -> grant order 0,1,2,3,0; each grant waits for the prior response handshake.
4. Core model never pulses mul_done -> after 64 WAIT cycles rsp_err = 1, rsp_data = 0 to the issuer; the next grant proceeds normally.
5. rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable and no new req_ready during the stall; a stray mul_done pulse in RESP/IDLE changes nothing.
6. Reset asserted during WAIT, then core done arrives -> outputs cleared, stale done ignored, no rsp_valid.
